mont_modexp_ctrl: RTL and testbench

- Sequences the shared pipelined Montgomery multiplier (M = 65521, R = 2^16) to compute modular exponentiation.
- Uses right-to-left binary square-and-multiply. The square and multiply of one exponent bit are independent, so both are issued back-to-back into the multiplier pipeline.
- Operands and result are in the Montgomery domain. The caller converts in and out.
- Sits between the crypto request bus and the multiplier instance.

---
 rtl/mont_pkg.sv | 26 ++
 rtl/mont_tag_fifo.sv | 57 +++++
 rtl/mont_modexp_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mont_modexp_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and types for the Montgomery modular-exponentiation controller.
//   MOD_M    : modulus, 65521
//   M_PRIME  : -M^-1 mod 2^16, used by the multiplier's reduction step
//   ONE_MONT : R mod M, which is 1 in the Montgomery domain
//   state_t  : controller FSM states
//   tag_t    : kind of an in-flight multiplication (square or multiply)
package mont_pkg;

    localparam logic [15:0] MOD_M    = 16'd65521;
    localparam logic [15:0] M_PRIME  = 16'd61167;
    localparam logic [15:0] ONE_MONT = 16'd15;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        ISSUE_B,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        SQ,
        MUL
    } tag_t;

endpackage

// File: rtl/mont_tag_fifo.sv
// Two-entry in-order queue of tags for multiplications in flight.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push      : enqueue push_tag (ignored when full unless a pop happens in the same cycle)
//   push_tag  : tag to enqueue
//   pop       : dequeue the head entry (ignored when empty)
//   head      : oldest tag in the queue
//   empty     : queue holds no tags
//   full      : queue holds two tags
//   count     : number of queued tags (0..2)
module mont_tag_fifo
    import mont_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  tag_t       push_tag,
    input  logic       pop,
    output tag_t       head,
    output logic       empty,
    output logic       full,
    output logic [1:0] count
);

    tag_t       mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign count   = cnt_q;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A pop frees the head slot this cycle, so a push into a full queue is safe then.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Modular-exponentiation sequencer driving a shared pipelined Montgomery multiplier.
// Right-to-left square-and-multiply; the square and multiply of one exponent bit are
// independent and are issued on consecutive cycles. All values are in Montgomery form.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   req_valid/req_ready               : request handshake; req_base, req_exp are the operands
//   resp_valid/resp_ready             : response handshake; resp_result = base^exp
//   busy                              : a request is in progress
//   err                               : sticky, mul_valid arrived with nothing outstanding
//   mul_a, mul_b, mul_start           : multiplier issue interface
//   mul_result, mul_valid             : multiplier return interface (in issue order)
module mont_modexp_ctrl
    import mont_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned EXP_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_base,
    input  logic [EXP_W-1:0] req_exp,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_result,
    output logic             busy,
    output logic             err,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    output logic             mul_start,
    input  logic [W-1:0]     mul_result,
    input  logic             mul_valid
);

    state_t           state_q, state_d;
    logic [W-1:0]     base_q, base_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic             err_q, err_d;

    logic             need_mul;
    logic             need_sq;

    logic             push;
    tag_t             push_tag;
    logic             pop;
    tag_t             head_tag;
    logic             tag_empty;
    logic             tag_full;
    logic [1:0]       tag_count;

    mont_tag_fifo u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head_tag),
        .empty    (tag_empty),
        .full     (tag_full),
        .count    (tag_count)
    );

    assign need_mul  = e_q[0];
    assign need_sq   = |e_q[EXP_W-1:1];
    assign pop       = mul_valid && !tag_empty;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        acc_d       = acc_q;
        e_d         = e_q;
        err_d       = err_q;
        mul_start   = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        push        = 1'b0;
        push_tag    = SQ;
        resp_valid  = 1'b0;
        resp_result = '0;

        // Results can land in any state, including ISSUE_B when the multiplier latency is 1.
        // Operands below read the _q registers, so a returning square never feeds the
        // multiply issued for the same exponent bit.
        if (pop) begin
            if (head_tag == SQ) begin
                base_d = mul_result;
            end else begin
                acc_d = mul_result;
            end
        end else if (mul_valid) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d  = req_base;
                    acc_d   = W'(ONE_MONT);
                    e_d     = req_exp;
                    err_d   = 1'b0;
                    state_d = (req_exp == '0) ? DONE : ISSUE_A;
                end
            end
            ISSUE_A: begin
                mul_start = 1'b1;
                push      = !tag_full;
                if (need_sq) begin
                    mul_a    = base_q;
                    mul_b    = base_q;
                    push_tag = SQ;
                end else begin
                    mul_a    = acc_q;
                    mul_b    = base_q;
                    push_tag = MUL;
                end
                state_d = (need_sq && need_mul) ? ISSUE_B : WAIT;
            end
            ISSUE_B: begin
                mul_start = 1'b1;
                mul_a     = acc_q;
                mul_b     = base_q;
                push      = !tag_full || pop;
                push_tag  = MUL;
                state_d   = WAIT;
            end
            WAIT: begin
                if (tag_count == 2'd0) begin
                    e_d     = e_q >> 1;
                    state_d = need_sq ? ISSUE_A : DONE;
                end
            end
            DONE: begin
                resp_valid  = 1'b1;
                resp_result = acc_q;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            acc_q   <= '0;
            e_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            e_q     <= e_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl with a behavioural pipelined Montgomery multiplier of
// selectable latency and a scoreboard of expected results.
module tb_mont_modexp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_base;
    logic [15:0] req_exp;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_result;
    logic        busy;
    logic        err;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_start;
    logic [15:0] mul_result;
    logic        mul_valid;

    int n_vec = 0;
    int n_bad = 0;
    int unsigned cycle = 0;

    mont_modexp_ctrl #(.W(16), .EXP_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_base    (req_base),
        .req_exp     (req_exp),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy),
        .err         (err),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_result  (mul_result),
        .mul_valid   (mul_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Montgomery product a*b*R^-1 mod M via REDC.
    function automatic logic [15:0] mont(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] t;
        logic [31:0] mp;
        logic [15:0] m;
        logic [32:0] u;
        logic [16:0] r;
        t  = 32'(a) * 32'(b);
        mp = 32'(t[15:0]) * 32'd61167;
        m  = mp[15:0];
        u  = 33'(t) + 33'(m) * 33'd65521;
        r  = u[32:16];
        if (r >= 17'd65521) r = r - 17'd65521;
        return r[15:0];
    endfunction

    // Expected result computed in the plain domain: x = bm/R, then x^e, then back to *R.
    function automatic logic [15:0] ref_exp(input logic [15:0] bm, input logic [15:0] e);
        longint unsigned x, r, bb;
        x  = (longint'(bm) * 61153) % 65521;  // 61153 = 15^-1 mod 65521
        r  = 1;
        bb = x;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) r = (r * bb) % 65521;
            bb = (bb * bb) % 65521;
        end
        return 16'((r * 15) % 65521);
    endfunction

    function automatic int muls(input logic [15:0] e);
        int n, msb;
        n = 0;
        msb = 0;
        for (int i = 0; i < 16; i++) begin
            if (e[i]) begin
                n++;
                msb = i;
            end
        end
        return (e == 16'd0) ? 0 : n + msb;
    endfunction

    // Behavioural multiplier: pipeline stages, output taken at stage lat-1.
    int          lat = 5;
    logic        pv [8];
    logic [15:0] pd [8];
    logic        inj = 1'b0;
    logic [15:0] inj_data = 16'd0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= mul_start;
            pd[0] <= mont(mul_a, mul_b);
            for (int i = 1; i < 8; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    always_comb begin
        mul_valid  = pv[lat-1] | inj;
        mul_result = inj ? inj_data : pd[lat-1];
    end

    // Issue log, sampled on the falling edge.
    logic [15:0] log_a[$];
    logic [15:0] log_b[$];
    int          log_c[$];

    always @(negedge clk) begin
        if (mul_start) begin
            log_a.push_back(mul_a);
            log_b.push_back(mul_b);
            log_c.push_back(int'(cycle));
        end
    end

    logic [15:0] sb[$];

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic do_req(input logic [15:0] b, input logic [15:0] e, input logic [15:0] res,
                          input int hold, output int acc_cyc, output int resp_cyc);
        int t;
        logic [15:0] exp_v;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        log_a.delete();
        log_b.delete();
        log_c.delete();
        req_valid = 1'b1;
        req_base  = b;
        req_exp   = e;
        sb.push_back(res);
        @(negedge clk);
        req_valid = 1'b0;
        acc_cyc   = int'(cycle);
        resp_cyc  = acc_cyc;
        check("err_after_accept", err, 0);
        t = 0;
        while (!resp_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!resp_valid) begin
            n_vec++;
            n_bad++;
            $display("FAIL resp_timeout: got no resp_valid, expected one (exp %0d)", e);
            void'(sb.pop_front());
            return;
        end
        resp_cyc = int'(cycle);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", resp_valid, 1);
            check("hold_result", resp_result, res);
            check("hold_req_ready", req_ready, 0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        exp_v = sb.pop_front();
        check("resp_result", resp_result, exp_v);
        check("err_during_run", err, 0);
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_valid_dropped", resp_valid, 0);
        check("busy_dropped", busy, 0);
        check("mul_count", log_c.size(), muls(e));
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] exp;
        logic [15:0] res;
    } vec_t;

    vec_t vecs [8];
    int   lats [3] = '{5, 1, 3};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ac, rc;
        vecs[0] = '{16'd45,    16'd0,      16'd15};
        vecs[1] = '{16'd45,    16'd1,      16'd45};
        vecs[2] = '{16'd45,    16'd5,      16'd3645};
        vecs[3] = '{16'd45,    16'hFFFF,   16'd62641};
        vecs[4] = '{16'd1234,  16'h00A7,   ref_exp(16'd1234, 16'h00A7)};
        vecs[5] = '{16'd60000, 16'h8001,   ref_exp(16'd60000, 16'h8001)};
        vecs[6] = '{16'd7,     16'd3,      ref_exp(16'd7, 16'd3)};
        vecs[7] = '{16'd0,     16'd9,      16'd0};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_base   = '0;
        req_exp    = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_err", err, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_resp_result", resp_result, 0);
        rst = 1'b0;

        foreach (lats[l]) begin
            lat = lats[l];
            for (int i = 0; i < 8; i++) begin
                do_req(vecs[i].base, vecs[i].exp, vecs[i].res, 0, ac, rc);
            end
        end

        lat = 5;
        // exp = 0: response in the cycle right after accept, no multiplications.
        do_req(16'd45, 16'd0, 16'd15, 0, ac, rc);
        check("exp0_resp_latency", rc - ac, 0);

        // exp = 1: a single multiply acc*base issued right after accept.
        do_req(16'd45, 16'd1, 16'd45, 0, ac, rc);
        check("exp1_first_cycle", log_c[0], ac);
        check("exp1_a", log_a[0], 15);
        check("exp1_b", log_b[0], 45);

        // exp = 5: SQ, MUL, SQ, MUL with the first pair back-to-back.
        do_req(16'd45, 16'd5, 16'd3645, 0, ac, rc);
        check("exp5_op0_a", log_a[0], 45);
        check("exp5_op0_b", log_b[0], 45);
        check("exp5_op1_a", log_a[1], 15);
        check("exp5_op1_b", log_b[1], 45);
        check("exp5_pair_adjacent", log_c[1] - log_c[0], 1);
        check("exp5_op2_a", log_a[2], 135);
        check("exp5_op2_b", log_b[2], 135);
        check("exp5_op3_a", log_a[3], 45);
        check("exp5_op3_b", log_b[3], 1215);

        // Response held while resp_ready stays low.
        do_req(16'd45, 16'hFFFF, 16'd62641, 3, ac, rc);

        // Reset in the middle of an exp = 5 run.
        @(negedge clk);
        req_valid = 1'b1;
        req_base  = 16'd45;
        req_exp   = 16'd5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_resp_valid", resp_valid, 0);
        check("mid_rst_mul_start", mul_start, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_err", err, 0);
        do_req(16'd45, 16'd1, 16'd45, 0, ac, rc);

        // Stray mul_valid while idle.
        @(negedge clk);
        inj      = 1'b1;
        inj_data = 16'd999;
        @(negedge clk);
        inj = 1'b0;
        check("stray_err_set", err, 1);
        repeat (3) @(negedge clk);
        check("stray_err_sticky", err, 1);
        check("stray_acc_kept", dut.acc_q, 45);
        check("stray_base_kept", dut.base_q, 45);
        check("stray_busy", busy, 0);
        do_req(16'd45, 16'd2, 16'd135, 0, ac, rc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
